noc_vc_rx_buffer: RTL and testbench

NOC_VC_RX_BUFFER -- requirements
Module: noc_vc_rx_buffer

---
 rtl/noc_vc_rx_buffer_if.sv | 41 ++++
 rtl/noc_vc_rx_buffer.sv | 142 ++++++++++++++
 tb/tb_noc_vc_rx_buffer.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/noc_vc_rx_buffer_if.sv
// Shared NoC widths/packet type and the VC link interface.
// Packet layout is {data, x, y}; credits return one-hot per VC.
package common_pkg;
  localparam int DEFAULT_VC_W = 2;
  localparam int DEFAULT_X_W  = 4;
  localparam int DEFAULT_Y_W  = 4;
  localparam int DEFAULT_D_W  = 8;

  typedef struct packed {
    logic [DEFAULT_D_W-1:0] data;
    logic [DEFAULT_X_W-1:0] x;
    logic [DEFAULT_Y_W-1:0] y;
  } noc_packet_s;
endpackage

interface noc_if
  import common_pkg::*;
#(
  parameter int VC_W = DEFAULT_VC_W,
  parameter int X_W  = DEFAULT_X_W,
  parameter int Y_W  = DEFAULT_Y_W,
  parameter int D_W  = DEFAULT_D_W
) ();
  localparam int PKT_W = D_W + X_W + Y_W;

  logic [VC_W-1:0]  vc_target;
  logic [PKT_W-1:0] packet;
  logic [VC_W-1:0]  vc_credit_gnt;

  modport sender (
    output vc_target,
    output packet,
    input  vc_credit_gnt
  );

  modport receiver (
    input  vc_target,
    input  packet,
    output vc_credit_gnt
  );
endinterface

// File: rtl/noc_vc_rx_buffer.sv
// Per-VC receive FIFOs with round-robin output and credit return.
// Optional sticky overflow flag: NOC_RX_OVERFLOW_CHECK_EN.
module noc_vc_rx_buffer
  import common_pkg::*;
#(
  parameter int VC_W  = DEFAULT_VC_W,
  parameter int X_W   = DEFAULT_X_W,
  parameter int Y_W   = DEFAULT_Y_W,
  parameter int D_W   = DEFAULT_D_W,
  parameter int DEPTH = 4,
  localparam int PKT_W = D_W + X_W + Y_W
) (
  input  logic             clk,
  input  logic             rst,
  noc_if.receiver          rx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [VC_W-1:0]  out_vc,
  output logic [PKT_W-1:0] out_packet,
  output logic             err_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = (VC_W > 1) ? $clog2(VC_W) : 1;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t state_q, state_d;

  logic [PKT_W-1:0] mem [VC_W][DEPTH];
  logic [AW:0]      wr_ptr [VC_W];
  logic [AW:0]      rd_ptr [VC_W];

  logic [VC_W-1:0] nempty;
  logic [VC_W-1:0] full;
  logic [VC_W-1:0] push;
  logic [VC_W-1:0] pop;
  logic [VC_W-1:0] gnt_q;

  logic [IW-1:0] rr_q;
  logic [IW-1:0] hold_q;
  logic [IW-1:0] pick;
  logic [IW-1:0] sel;
  logic          found;
  logic          accept;

  for (genvar i = 0; i < VC_W; i++) begin : g_vc
    assign nempty[i] = wr_ptr[i] != rd_ptr[i];
    assign full[i] =
      (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
      (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);

    // Advance write/read pointers on accepted push and pop.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end else begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
      end
    end

    // Store the incoming packet at the write slot.
    always_ff @(posedge clk) begin
      if (push[i]) mem[i][wr_ptr[i][AW-1:0]] <= rx.packet;
    end
  end

  // Round-robin search from the priority pointer.
  always_comb begin
    pick  = rr_q;
    found = 1'b0;
    for (int k = 0; k < VC_W; k++) begin
      if (!found && nempty[(int'(rr_q) + k) % VC_W]) begin
        pick  = IW'((int'(rr_q) + k) % VC_W);
        found = 1'b1;
      end
    end
  end

  // Selection FSM: lock the presented VC while stalled.
  always_comb begin
    state_d   = state_q;
    sel       = pick;
    out_valid = found;
    if (state_q == HOLD) begin
      sel       = hold_q;
      out_valid = 1'b1;
    end
    accept = out_valid && out_ready;
    unique case (state_q)
      IDLE: if (out_valid && !out_ready) state_d = HOLD;
      HOLD: if (out_ready) state_d = IDLE;
    endcase
  end

  assign out_vc = out_valid ? (VC_W'(1) << sel) : '0;
  assign out_packet = mem[sel][rd_ptr[sel][AW-1:0]];
  assign pop = out_vc & {VC_W{out_ready}};
  assign push = rx.vc_target & (~full | pop);
  assign rx.vc_credit_gnt = gnt_q;

  // FSM state, locked VC, rr pointer and registered credits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      rr_q    <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= pop;
      if (state_q == IDLE && state_d == HOLD) hold_q <= sel;
      if (accept) rr_q <= IW'((int'(sel) + 1) % VC_W);
    end
  end

`ifdef NOC_RX_OVERFLOW_CHECK_EN
  logic [VC_W-1:0] drop;
  logic            err_q;

  assign drop = rx.vc_target & full & ~pop;

  // Sticky flag set one cycle after any dropped push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else if (|drop) err_q <= 1'b1;
  end

  assign err_overflow = err_q;

`ifdef SIMULATION
  a_no_drop: assert property (
    @(posedge clk) disable iff (rst) !(|drop)
  ) else $error("push to full VC dropped");
`endif
`else
  assign err_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_noc_vc_rx_buffer.sv
// Directed bench for noc_vc_rx_buffer, VC_W=2 DEPTH=4.
// Inputs change 1ns after posedge; outputs checked 1ns later.
module tb_noc_vc_rx_buffer;
  import common_pkg::*;

  localparam int VC_W  = 2;
  localparam int X_W   = 4;
  localparam int Y_W   = 4;
  localparam int D_W   = 8;
  localparam int PKT_W = D_W + X_W + Y_W;

  logic             clk;
  logic             rst;
  logic             out_valid;
  logic             out_ready;
  logic [VC_W-1:0]  out_vc;
  logic [PKT_W-1:0] out_packet;
  logic             err_overflow;

  int n_cmp;
  int n_bad;

  noc_if #(.VC_W(VC_W), .X_W(X_W), .Y_W(Y_W), .D_W(D_W)) rxif ();

  noc_vc_rx_buffer #(
    .VC_W(VC_W), .X_W(X_W), .Y_W(Y_W), .D_W(D_W), .DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx(rxif),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_vc(out_vc),
    .out_packet(out_packet),
    .err_overflow(err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PKT_W-1:0] mk(input logic [7:0] d);
    return {d, 4'h3, 4'h5};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    out_ready = 1'b0;
    rxif.vc_target = '0;
    rxif.packet = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [1:0] vc, input logic [7:0] d);
    rxif.vc_target = vc;
    rxif.packet = mk(d);
    tick();
    rxif.vc_target = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b0;
    rxif.vc_target = '0;
    rxif.packet = '0;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_valid: got %b want 0", out_valid);
    end
    n_cmp++;
    if (out_vc !== 2'b00) begin
      n_bad++; $display("FAIL rst_vc: got %b want 00", out_vc);
    end
    n_cmp++;
    if (rxif.vc_credit_gnt !== 2'b00) begin
      n_bad++;
      $display("FAIL rst_gnt: got %b want 00", rxif.vc_credit_gnt);
    end
    n_cmp++;
    if (err_overflow !== 1'b0) begin
      n_bad++; $display("FAIL rst_err: got %b want 0", err_overflow);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_push();
    do_reset();
    out_ready = 1'b1;
    push(2'b01, 8'hA5);
    #1;
    n_cmp++;
    if (out_valid !== 1'b1 || out_vc !== 2'b01) begin
      n_bad++;
      $display("FAIL single_vis: got v=%b vc=%b want v=1 vc=01",
               out_valid, out_vc);
    end
    n_cmp++;
    if (out_packet !== mk(8'hA5)) begin
      n_bad++;
      $display("FAIL single_data: got %h want %h", out_packet, mk(8'hA5));
    end
    n_cmp++;
    if (rxif.vc_credit_gnt !== 2'b00) begin
      n_bad++;
      $display("FAIL single_gnt_t1: got %b want 00", rxif.vc_credit_gnt);
    end
    tick();
    n_cmp++;
    if (rxif.vc_credit_gnt !== 2'b01 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_gnt_t2: got gnt=%b v=%b want gnt=01 v=0",
               rxif.vc_credit_gnt, out_valid);
    end
    tick();
    n_cmp++;
    if (rxif.vc_credit_gnt !== 2'b00) begin
      n_bad++;
      $display("FAIL single_gnt_t3: got %b want 00", rxif.vc_credit_gnt);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int k = 0; k < 4; k++) push(2'b10, 8'(8'h10 + k));
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if (out_vc !== 2'b10 || out_packet !== mk(8'h10) ||
          rxif.vc_credit_gnt !== 2'b00) begin
        n_bad++;
        $display("FAIL fill_hold: got vc=%b pkt=%h gnt=%b want 10 %h 00",
                 out_vc, out_packet, rxif.vc_credit_gnt, mk(8'h10));
      end
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++;
      if (out_vc !== 2'b10 || out_packet !== mk(8'(8'h10 + k))) begin
        n_bad++;
        $display("FAIL drain_%0d: got vc=%b pkt=%h want 10 %h",
                 k, out_vc, out_packet, mk(8'(8'h10 + k)));
      end
      tick();
      n_cmp++;
      if (rxif.vc_credit_gnt !== 2'b10) begin
        n_bad++;
        $display("FAIL drain_gnt_%0d: got %b want 10",
                 k, rxif.vc_credit_gnt);
      end
    end
    tick();
    n_cmp++;
    if (rxif.vc_credit_gnt !== 2'b00 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL drain_end: got gnt=%b v=%b want 00 0",
               rxif.vc_credit_gnt, out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [1:0] ev;
    logic [7:0] ed;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      push(2'b01, 8'(8'h20 + k));
      push(2'b10, 8'(8'h30 + k));
    end
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      ev = (k % 2 == 0) ? 2'b01 : 2'b10;
      ed = (k % 2 == 0) ? 8'(8'h20 + k / 2) : 8'(8'h30 + k / 2);
      #1;
      n_cmp++;
      if (out_vc !== ev || out_packet !== mk(ed)) begin
        n_bad++;
        $display("FAIL rr_%0d: got vc=%b pkt=%h want %b %h",
                 k, out_vc, out_packet, ev, mk(ed));
      end
      tick();
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL rr_end: got v=%b want 0", out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_hold();
    do_reset();
    out_ready = 1'b1;
    push(2'b01, 8'h3F);
    tick();
    out_ready = 1'b0;
    push(2'b01, 8'h40);
    push(2'b10, 8'h50);
    for (int c = 0; c < 2; c++) begin
      #1;
      n_cmp++;
      if (out_vc !== 2'b01 || out_packet !== mk(8'h40)) begin
        n_bad++;
        $display("FAIL hold_%0d: got vc=%b pkt=%h want 01 %h",
                 c, out_vc, out_packet, mk(8'h40));
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    n_cmp++;
    if (out_vc !== 2'b10 || out_packet !== mk(8'h50)) begin
      n_bad++;
      $display("FAIL hold_next: got vc=%b pkt=%h want 10 %h",
               out_vc, out_packet, mk(8'h50));
    end
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    logic exp_err;
`ifdef NOC_RX_OVERFLOW_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    do_reset();
    for (int k = 0; k < 4; k++) push(2'b01, 8'(8'h60 + k));
    out_ready = 1'b1;
    push(2'b01, 8'h64);
    out_ready = 1'b0;
    n_cmp++;
    if (rxif.vc_credit_gnt !== 2'b01 || err_overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL pp_full: got gnt=%b err=%b want 01 0",
               rxif.vc_credit_gnt, err_overflow);
    end
    n_cmp++;
    if (out_packet !== mk(8'h61)) begin
      n_bad++;
      $display("FAIL pp_head: got %h want %h", out_packet, mk(8'h61));
    end
    push(2'b01, 8'h65);
    n_cmp++;
    if (err_overflow !== exp_err || rxif.vc_credit_gnt !== 2'b00) begin
      n_bad++;
      $display("FAIL ovf_err: got err=%b gnt=%b want %b 00",
               err_overflow, rxif.vc_credit_gnt, exp_err);
    end
    out_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_packet !== mk(8'(8'h60 + k))) begin
        n_bad++;
        $display("FAIL ovf_drain_%0d: got v=%b pkt=%h want 1 %h",
                 k, out_valid, out_packet, mk(8'(8'h60 + k)));
      end
      tick();
    end
    n_cmp++;
    if (out_valid !== 1'b0 || err_overflow !== exp_err) begin
      n_bad++;
      $display("FAIL ovf_end: got v=%b err=%b want 0 %b",
               out_valid, err_overflow, exp_err);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    push(2'b01, 8'h70);
    push(2'b10, 8'h80);
    push(2'b01, 8'h71);
    push(2'b10, 8'h81);
    out_ready = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_vc !== 2'b00 ||
        rxif.vc_credit_gnt !== 2'b00 || err_overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_now: got v=%b vc=%b gnt=%b err=%b want 0",
               out_valid, out_vc, rxif.vc_credit_gnt, err_overflow);
    end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b0 || rxif.vc_credit_gnt !== 2'b00) begin
        n_bad++;
        $display("FAIL midrst_after_%0d: got v=%b gnt=%b want 0 00",
                 c, out_valid, rxif.vc_credit_gnt);
      end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    out_ready = 1'b0;
    rxif.vc_target = '0;
    rxif.packet = '0;
    test_reset();
    test_single_push();
    test_fill_drain();
    test_round_robin();
    test_hold();
    test_full_push_pop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
